// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serializes valid/ready words MSB first onto the chain head
// and terminates after CHAIN_LEN bits. Optional tail readback enabled by CCFF_READBACK_EN.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 25,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int IDX_W  = $clog2(WORD_W+1);
  localparam int WC_W   = $clog2(NWORDS+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  bidx_q, bidx_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              head_q, shen_q, busy_q, done_q;
  logic              last_word_bit, last_chain, words_left, accept, start_ok;

  assign last_word_bit = (bidx_q == IDX_W'(WORD_W-1));
  assign last_chain    = (cnt_q == CNT_W'(CHAIN_LEN-1));
  assign words_left    = (wcnt_q < WC_W'(NWORDS));
  assign start_ok      = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    word_ready = 1'b0;
    case (state_q)
      S_FETCH: word_ready = 1'b1;
      S_SHIFT: word_ready = last_word_bit && !last_chain && words_left;
      default: word_ready = 1'b0;
    endcase
  end

  assign accept = word_ready && word_valid;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bidx_d  = bidx_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          wcnt_d  = '0;
        end
      end
      S_FETCH: begin
        if (accept) begin
          state_d = S_SHIFT;
          shreg_d = word_data;
          bidx_d  = '0;
          wcnt_d  = wcnt_q + WC_W'(1);
        end
      end
      default: begin
        shreg_d = shreg_q << 1;
        bidx_d  = bidx_q + IDX_W'(1);
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_chain) begin
          state_d = S_DONE;
        end else if (accept) begin
          // back-to-back word: reload without a bubble on the chain
          shreg_d = word_data;
          bidx_d  = '0;
          wcnt_d  = wcnt_q + WC_W'(1);
        end else if (last_word_bit) begin
          state_d = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bidx_q  <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      head_q  <= 1'b0;
      shen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bidx_q  <= bidx_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      head_q  <= (state_d == S_SHIFT) && shreg_d[WORD_W-1];
      shen_q  <= (state_d == S_SHIFT);
      busy_q  <= (state_d == S_FETCH) || (state_d == S_SHIFT);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shen_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bit_count     = cnt_q;

`ifdef CCFF_READBACK_EN
  localparam int RB_W = $clog2(WORD_W+1);

  logic [WORD_W-1:0] acc_q, acc_d, acc_n, rbd_q, rbd_d;
  logic [RB_W-1:0]   rbn_q, rbn_d, rbn_n;
  logic              rbv_q, rbv_d;

  assign acc_n = (acc_q << 1) | WORD_W'(ccff_tail);
  assign rbn_n = rbn_q + RB_W'(1);

  always_comb begin
    acc_d = acc_q;
    rbn_d = rbn_q;
    rbd_d = rbd_q;
    rbv_d = 1'b0;
    if (start_ok) begin
      acc_d = '0;
      rbn_d = '0;
    end else if (shen_q) begin
      if (rbn_n == RB_W'(WORD_W) || last_chain) begin
        // partial final word comes out left-aligned, zero-padded
        rbd_d = acc_n << (RB_W'(WORD_W) - rbn_n);
        rbv_d = 1'b1;
        acc_d = '0;
        rbn_d = '0;
      end else begin
        acc_d = acc_n;
        rbn_d = rbn_n;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      acc_q <= '0;
      rbn_q <= '0;
      rbd_q <= '0;
      rbv_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      rbn_q <= rbn_d;
      rbd_q <= rbd_d;
      rbv_q <= rbv_d;
    end
  end

  assign rb_data  = rbd_q;
  assign rb_valid = rbv_q;
`else
  logic unused_rb;
  assign unused_rb = ccff_tail ^ start_ok;
  assign rb_data   = '0;
  assign rb_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader: expected chain bits are queued by the
// stimulus and popped by negedge monitors whenever shift enable is high.
module tb_ccff_bitstream_loader;
  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       pReset = 1'b1;
  logic       start = 1'b0, word_valid = 1'b0, word_ready;
  logic [7:0] word_data = 8'h00;
  logic       ccff_head, ccff_shift_en, ccff_tail, busy, done, rb_valid;
  logic [4:0] bit_count;
  logic [7:0] rb_data;

  logic       start8 = 1'b0, wv8 = 1'b0, wr8, head8, shen8, busy8, done8, rbv8_unused;
  logic [7:0] wd8 = 8'h00, rbd8_unused;
  logic [3:0] bc8;

  ccff_bitstream_loader #(.CHAIN_LEN(25), .WORD_W(8)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
    .bit_count(bit_count), .rb_data(rb_data), .rb_valid(rb_valid));

  ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start8), .word_data(wd8),
    .word_valid(wv8), .word_ready(wr8), .ccff_head(head8), .ccff_shift_en(shen8),
    .ccff_tail(1'b0), .busy(busy8), .done(done8), .bit_count(bc8),
    .rb_data(rbd8_unused), .rb_valid(rbv8_unused));

  // downstream chain model: old contents emerge at the tail as new bits enter the head
  logic [24:0] chain_m;
  logic        preload = 1'b1;
  assign ccff_tail = chain_m[24];
  always @(posedge prog_clk) begin
    if (preload) chain_m <= '1;
    else if (ccff_shift_en) chain_m <= {chain_m[23:0], ccff_head};
  end

  int   n_chk = 0, n_err = 0;
  bit   exp_q[$];
  bit   exp8_q[$];
  logic [7:0] rb_q[$];
  int   hs = 0, shifts = 0, runs = 0, hs8 = 0, shifts8 = 0;
  logic shen_prev = 1'b0, last8 = 1'b0;
  bit   rb_chk = 1'b0;

  localparam logic [24:0] BITS = 25'b1010010100111100111100001;
  localparam logic [7:0]  W0 = 8'hA5, W1 = 8'h3C, W2 = 8'hF0, W3 = 8'h80;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got output with no queued expectation, expected none", name);
  endtask

  always @(negedge prog_clk) begin
    if (word_valid === 1'b1 && word_ready === 1'b1) hs++;
    if (ccff_shift_en === 1'b1) begin
      shifts++;
      if (shen_prev !== 1'b1) runs++;
      if (exp_q.size() == 0) miss("head_extra");
      else check("head_bit", ccff_head, exp_q.pop_front());
    end
    shen_prev = ccff_shift_en;
    if (rb_valid === 1'b1 && rb_chk) begin
      if (rb_q.size() == 0) miss("rb_extra");
      else check("rb_data", rb_data, rb_q.pop_front());
    end
  end

  always @(negedge prog_clk) begin
    if (wv8 === 1'b1 && wr8 === 1'b1) hs8++;
    if (shen8 === 1'b1) begin
      shifts8++;
      last8 = head8;
      if (exp8_q.size() == 0) miss("head8_extra");
      else check("head8_bit", head8, exp8_q.pop_front());
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 100 && word_ready !== 1'b1; i++) @(negedge prog_clk);
  endtask

  task automatic feed(input int gap_at);
    logic [7:0] w [4];
    w[0] = W0; w[1] = W1; w[2] = W2; w[3] = W3;
    for (int k = 0; k < 4; k++) begin
      if (k == gap_at) begin
        word_valid = 1'b0;
        @(negedge prog_clk);
        wait_ready();
        repeat (3) @(posedge prog_clk);
        #1;
      end
      word_data  = w[k];
      word_valid = 1'b1;
      @(negedge prog_clk);
      wait_ready();
      check("word_ready", word_ready, 1);
      @(posedge prog_clk);
      #1;
    end
    word_data = 8'h5A;
  endtask

  task automatic do_start();
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_count", bit_count, 0);
  endtask

  task automatic run_load(input int gap_at, input int exp_runs, input bit start_mid);
    hs = 0; shifts = 0; runs = 0;
    for (int i = 24; i >= 0; i--) exp_q.push_back(BITS[i]);
    do_start();
    fork
      feed(gap_at);
      if (start_mid) begin
        repeat (5) @(posedge prog_clk);
        #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
      end
    join
    word_valid = 1'b0;
    for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge prog_clk);
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("bit_count_end", bit_count, 25);
    check("shift_cycles", shifts, 25);
    check("shift_runs", runs, exp_runs);
    check("handshakes", hs, 4);
    check("exp_left", exp_q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_head"}, ccff_head, 0);
    check({tag, "_shen"}, ccff_shift_en, 0);
    check({tag, "_ready"}, word_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, bit_count, 0);
    check({tag, "_rbdata"}, rb_data, 0);
    check({tag, "_rbvalid"}, rb_valid, 0);
  endtask

  initial begin
    repeat (3) @(posedge prog_clk);
    #1;
    check_reset("rst");
    pReset = 1'b0;
    preload = 1'b0;

    // back-to-back words, with readback of a chain preloaded with ones
`ifdef CCFF_READBACK_EN
    rb_q.push_back(8'hFF); rb_q.push_back(8'hFF); rb_q.push_back(8'hFF); rb_q.push_back(8'h80);
    rb_chk = 1'b1;
`endif
    run_load(-1, 1, 1'b0);
    repeat (2) @(posedge prog_clk);
`ifdef CCFF_READBACK_EN
    check("rb_left", rb_q.size(), 0);
    check("rb_hold", rb_data, 8'h80);
    rb_chk = 1'b0;
`endif
    // valid offered in DONE must not be consumed
    #1 word_valid = 1'b1;
    repeat (4) @(posedge prog_clk);
    #1 word_valid = 1'b0;
    check("hs_in_done", hs, 4);
    check("done_hold", done, 1);

    // stall before word 2 (0xF0)
    run_load(2, 2, 1'b0);

    // mid-load reset after 10 bits
    hs = 0; shifts = 0; runs = 0;
    for (int i = 24; i >= 0; i--) exp_q.push_back(BITS[i]);
    do_start();
    word_data = W0; word_valid = 1'b1;
    @(negedge prog_clk); wait_ready();
    @(posedge prog_clk); #1 word_data = W1;
    for (int i = 0; i < 100 && bit_count !== 5'd10; i++) @(negedge prog_clk);
    check("count_at_reset", bit_count, 10);
    pReset = 1'b1;
    @(posedge prog_clk); #1;
    check_reset("midrst");
    pReset = 1'b0; word_valid = 1'b0;
    exp_q.delete();
    run_load(-1, 1, 1'b0);

    // start during SHIFT ignored, then restart from DONE
    run_load(-1, 1, 1'b1);
    run_load(-1, 1, 1'b0);

    // single-word 8-bit chain
    for (int i = 7; i >= 0; i--) exp8_q.push_back(i == 0);
    @(posedge prog_clk); #1 start8 = 1'b1;
    @(posedge prog_clk); #1 start8 = 1'b0; wd8 = 8'h01; wv8 = 1'b1;
    for (int i = 0; i < 200 && done8 !== 1'b1; i++) @(negedge prog_clk);
    repeat (3) @(negedge prog_clk);
    wv8 = 1'b0;
    check("c8_done", done8, 1);
    check("c8_busy", busy8, 0);
    check("c8_handshakes", hs8, 1);
    check("c8_shifts", shifts8, 8);
    check("c8_last_head", last8, 1);
    check("c8_count", bc8, 8);
    check("c8_exp_left", exp8_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
Configuration-chain driver that sits directly upstream of the routing/connection-block configuration chain. It accepts configuration words over a valid/ready interface and serializes them, MSB first, onto the chain's head input. It emits a shift-enable that gates prog_clk to the chain, and it terminates after exactly CHAIN_LEN bits. Default sizing matches a 10-IPIN cbx tile: 5 × 3-bit + 5 × 2-bit mux memories = 25 bits.

Parameters:
CHAIN_LEN, 25, total configuration bits in the downstream chain (>=1)
WORD_W, 8, bitstream word width (>=1)
CNT_W, $clog2(CHAIN_LEN+1), width of bit_count

Ports:
prog_clk  input  1  programming clock; all state on rising edge
pReset  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled in IDLE or DONE only
word_data  input  WORD_W  configuration word, MSB shifted first
word_valid  input  1  word_data valid
word_ready  output  1  loader accepts word_data this cycle
ccff_head  output  1  serial bit to the chain head
ccff_shift_en  output  1  enables prog_clk to the chain this cycle (clock-gate enable)
ccff_tail  input  1  serial bit returning from the chain tail
busy  output  1  load in progress
done  output  1  all CHAIN_LEN bits shifted; held until restart
bit_count  output  CNT_W  bits shifted so far in the current load
rb_data  output  WORD_W  readback word (optional feature)
rb_valid  output  1  readback word strobe (optional feature)

Behaviour:
- Reset: one clock interface only. Reset is synchronous and active-high on pReset, sampled on the rising edge of prog_clk.
- Reset values (also forced on any cycle pReset is high, including mid-load):
  - state=IDLE
  - ccff_head=0, ccff_shift_en=0, word_ready=0
  - busy=0, done=0, bit_count=0
  - rb_data=0, rb_valid=0
  - Chain contents are undefined after a mid-load reset; software must reload.
- Word schedule: NWORDS = ceil(CHAIN_LEN/WORD_W). The last word contributes only its top LAST = CHAIN_LEN − (NWORDS−1)·WORD_W bits; its low bits are discarded.
- FSM states: IDLE, FETCH, SHIFT, DONE.
  - IDLE/DONE, start=1 → FETCH. On entry: busy=1, done=0, bit_count=0.
  - FETCH: word_ready=1. On word_valid&word_ready, load the shift register and word index and go to SHIFT.
  - SHIFT: ccff_head = shreg MSB, ccff_shift_en=1. Each cycle: shift left, bit_count++.
    - On the last bit of the word, or the last bit of the chain, word_ready=1 only if words remain.
    - If a word is accepted on that cycle → stay in SHIFT with no bubble.
    - If words remain but none is accepted → FETCH. The chain is stalled (shift_en=0); this is legal, with no underrun error.
    - If the bit with bit_count==CHAIN_LEN−1 is shifted → DONE.
  - DONE: busy=0, done=1, shift_en=0, word_ready=0.
- Latency: a word accepted in cycle N drives ccff_head from cycle N+1.
- Ordering: the first bit shifted ends at the far (tail) end of the chain.
- ccff_shift_en is registered together with ccff_head, so both change in the same cycle.
- start while busy is ignored. start and pReset in the same cycle: reset wins.
- word_valid outside the ready cycles is ignored. No word is consumed beyond NWORDS.
- bit_count never exceeds CHAIN_LEN.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- Defined:
  - On every cycle ccff_shift_en=1, sample ccff_tail (old chain contents emerging) into an accumulator, MSB first.
  - rb_valid pulses 1 cycle with rb_data after every WORD_W sampled bits.
  - After the final chain bit, any partial word is emitted left-aligned and zero-padded.
  - rb_data holds its value between strobes. There is no backpressure.
- Not defined: ccff_tail is ignored, and rb_data/rb_valid are tied to 0.

Test Plan:
1. Reset, then start; words 0xA5, 0x3C, 0xF0, 0x80 offered back-to-back with valid=1 → ccff_head sequence 10100101 00111100 11110000 1. The shift_en high run is exactly 25 contiguous cycles. done=1 and bit_count=25 after the run. Only 4 handshakes occur.
2. Same words with a 3-cycle word_valid gap after word 2 → shift_en=0 for the gap cycles, ccff_head resumes with 0xF0's MSB, and the total shifted bits are still 25.
3. pReset asserted after 10 bits shifted → next cycle all outputs hold their reset values. A new start reloads the full 25 bits correctly.
4. start pulsed during SHIFT → ignored (bit sequence unchanged). start in DONE → done clears and the load repeats.
5. CCFF_READBACK_EN, ccff_tail modelled as the chain output preloaded with 25 ones → rb_valid pulses 4 times: 0xFF, 0xFF, 0xFF, 0x80.
6. CHAIN_LEN=8, WORD_W=8, word 0x01 → exactly one handshake, 8 shift cycles, and the last ccff_head bit is 1.
